// File: rtl/link_pkg.sv
// Shared definitions for the serial move link: reserved ACK code, FSM states and
// default packet width.
package link_pkg;

   localparam int         PKT_LEN_DEF = 8;
   localparam logic [7:0] ACK_CODE    = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_ACK,
      ST_WAIT_TX_ACK,
      ST_SEND_MOVE,
      ST_WAIT_TX_MOVE,
      ST_WAIT_ACK,
      ST_ERROR
   } link_state_t;

endpackage

// File: rtl/link_timer.sv
// ACK timeout down-counter: load arms it to ACK_TIMEOUT-1, en counts down,
// expired is high while the count sits at zero.
module link_timer #(
   parameter int ACK_TIMEOUT = 6_500_000
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic load_in,
   input  logic en_in,
   output logic expired_out
);

   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   logic [TW-1:0] count_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         count_q <= '0;
      end else if (load_in) begin
         count_q <= TW'(ACK_TIMEOUT - 1);
      end else if (en_in && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign expired_out = (count_q == '0);

endmodule

// File: rtl/move_link_ctrl.sv
// Move link sequencer: arbitrates tx between owed ACKs and the local move,
// confirms outgoing moves with ACK/timeout/retry, and drops duplicate rx moves.
//
// state          | meaning
// ST_IDLE        | pick next tx job (ACK before move) once tx is free
// ST_SEND_ACK    | one-cycle trigger with ACK code
// ST_WAIT_TX_ACK | wait for serializer to finish the ACK
// ST_SEND_MOVE   | one-cycle trigger with local move
// ST_WAIT_TX_MOVE| wait for serializer to finish the move
// ST_WAIT_ACK    | waiting for peer ACK (or implicit ACK) until timeout
// ST_ERROR       | retries exhausted; link dead until reset
module move_link_ctrl
   import link_pkg::*;
#(
   parameter int ACK_TIMEOUT = 6_500_000,
   parameter int MAX_RETRY   = 3,
   parameter int PKT_LEN     = PKT_LEN_DEF
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               move_req_in,
   input  logic [PKT_LEN-1:0] move_in,
   input  logic               rx_valid_in,
   input  logic [PKT_LEN-1:0] rx_data_in,
   input  logic               tx_busy_in,
   output logic               tx_trigger_out,
   output logic [PKT_LEN-1:0] tx_data_out,
   output logic               move_valid_out,
   output logic [PKT_LEN-1:0] move_out,
   output logic               req_ready_out,
   output logic               link_err_out
);

   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [PKT_LEN-1:0] ACK_PKT = PKT_LEN'(ACK_CODE);

   link_state_t        state_q, state_d;
   logic               move_pend_q, move_pend_d;
   logic               ack_pend_q, ack_pend_d;
   logic [PKT_LEN-1:0] move_reg_q, move_reg_d;
   logic [PKT_LEN-1:0] last_rx_q, last_rx_d;
   logic               dup_ok_q, dup_ok_d;
   logic [RW-1:0]      retry_q, retry_d;
   logic               move_valid_q, move_valid_d;
   logic [PKT_LEN-1:0] move_out_q, move_out_d;
   logic [PKT_LEN-1:0] tx_data_q, tx_data_d;
   logic               req_ready_q, req_ready_d;
   logic               guard_q, guard_d;
   logic               tmr_load, tmr_en, tmr_expired;
   logic               rx_move, rx_ack, rx_dup;

   link_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .load_in     (tmr_load),
      .en_in       (tmr_en),
      .expired_out (tmr_expired)
   );

   assign rx_move = rx_valid_in && (state_q != ST_ERROR) && (rx_data_in != ACK_PKT);
   assign rx_ack  = rx_valid_in && (state_q == ST_WAIT_ACK) && (rx_data_in == ACK_PKT);
   assign rx_dup  = dup_ok_q && (rx_data_in == last_rx_q);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= ST_IDLE;
         move_pend_q  <= 1'b0;
         ack_pend_q   <= 1'b0;
         move_reg_q   <= '0;
         last_rx_q    <= '0;
         dup_ok_q     <= 1'b0;
         retry_q      <= '0;
         move_valid_q <= 1'b0;
         move_out_q   <= '0;
         tx_data_q    <= '0;
         req_ready_q  <= 1'b0;
         guard_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         move_pend_q  <= move_pend_d;
         ack_pend_q   <= ack_pend_d;
         move_reg_q   <= move_reg_d;
         last_rx_q    <= last_rx_d;
         dup_ok_q     <= dup_ok_d;
         retry_q      <= retry_d;
         move_valid_q <= move_valid_d;
         move_out_q   <= move_out_d;
         tx_data_q    <= tx_data_d;
         req_ready_q  <= req_ready_d;
         guard_q      <= guard_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      move_pend_d  = move_pend_q;
      ack_pend_d   = ack_pend_q;
      move_reg_d   = move_reg_q;
      last_rx_d    = last_rx_q;
      dup_ok_d     = dup_ok_q;
      retry_d      = retry_q;
      move_valid_d = 1'b0;
      move_out_d   = move_out_q;
      tx_data_d    = tx_data_q;
      tmr_load     = 1'b0;
      tmr_en       = 1'b0;
      guard_d      = (state_q == ST_SEND_ACK) || (state_q == ST_SEND_MOVE);

      if (move_req_in && req_ready_q) begin
         move_pend_d = 1'b1;
         move_reg_d  = move_in;
      end

      case (state_q)
         ST_IDLE: begin
            if (!tx_busy_in) begin
               if (ack_pend_q) begin
                  state_d   = ST_SEND_ACK;
                  tx_data_d = ACK_PKT;
               end else if (move_pend_q) begin
                  state_d   = ST_SEND_MOVE;
                  tx_data_d = move_reg_q;
               end
            end
         end
         ST_SEND_ACK:  state_d = ST_WAIT_TX_ACK;
         ST_SEND_MOVE: state_d = ST_WAIT_TX_MOVE;
         ST_WAIT_TX_ACK: begin
            if (!guard_q && !tx_busy_in) begin
               ack_pend_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         ST_WAIT_TX_MOVE: begin
            if (!guard_q && !tx_busy_in) begin
               tmr_load = 1'b1;
               dup_ok_d = 1'b0;
               state_d  = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            tmr_en = 1'b1;
            // A fresh peer move proves our move arrived, so it counts as the ACK.
            if (rx_ack || rx_move) begin
               move_pend_d = 1'b0;
               retry_d     = '0;
               state_d     = ST_IDLE;
            end else if (tmr_expired) begin
               if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d = retry_q + 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_ERROR;
               end
            end
         end
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_IDLE;
      endcase

      // Applied last so a new rx move wins over same-cycle clears of ack_pend/dup_ok.
      if (rx_move) begin
         ack_pend_d = 1'b1;
         if (!rx_dup) begin
            move_valid_d = 1'b1;
            move_out_d   = rx_data_in;
            last_rx_d    = rx_data_in;
            dup_ok_d     = 1'b1;
         end
      end

      req_ready_d = !move_pend_d && (state_d != ST_ERROR);
   end

   assign tx_trigger_out = (state_q == ST_SEND_ACK) || (state_q == ST_SEND_MOVE);
   assign tx_data_out    = tx_data_q;
   assign move_valid_out = move_valid_q;
   assign move_out       = move_out_q;
   assign req_ready_out  = req_ready_q;
   assign link_err_out   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_move_link_ctrl.sv
// Directed bench for move_link_ctrl with a behavioural tx serializer (busy for
// 8 cycles per trigger) and a short ACK timeout.
module tb_move_link_ctrl;

   localparam int TMO = 100;
   localparam int MR  = 3;

   logic       clk_in = 1'b0;
   logic       rst_n_in = 1'b0;
   logic       move_req_in = 1'b0;
   logic [7:0] move_in = 8'h00;
   logic       rx_valid_in = 1'b0;
   logic [7:0] rx_data_in = 8'h00;
   logic       tx_busy_in = 1'b0;
   logic       tx_trigger_out;
   logic [7:0] tx_data_out;
   logic       move_valid_out;
   logic [7:0] move_out;
   logic       req_ready_out;
   logic       link_err_out;

   move_link_ctrl #(.ACK_TIMEOUT(TMO), .MAX_RETRY(MR), .PKT_LEN(8)) dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .move_req_in    (move_req_in),
      .move_in        (move_in),
      .rx_valid_in    (rx_valid_in),
      .rx_data_in     (rx_data_in),
      .tx_busy_in     (tx_busy_in),
      .tx_trigger_out (tx_trigger_out),
      .tx_data_out    (tx_data_out),
      .move_valid_out (move_valid_out),
      .move_out       (move_out),
      .req_ready_out  (req_ready_out),
      .link_err_out   (link_err_out)
   );

   initial forever #5 clk_in = ~clk_in;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // tx serializer model and output monitor, sampled on the falling edge
   int         busy_cnt = 0;
   int         cyc = 0;
   logic [7:0] trig_q[$];
   int         trig_t[$];
   int         mv_cnt = 0;
   logic [7:0] mv_last = 8'h00;

   initial forever begin
      @(negedge clk_in);
      cyc++;
      if (!rst_n_in) begin
         tx_busy_in = 1'b0;
         busy_cnt   = 0;
      end else begin
         if (tx_trigger_out) begin
            trig_q.push_back(tx_data_out);
            trig_t.push_back(cyc);
            tx_busy_in = 1'b1;
            busy_cnt   = 8;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy_in = 1'b0;
         end
         if (move_valid_out) begin
            mv_cnt++;
            mv_last = move_out;
         end
      end
   end

   function automatic logic [7:0] trig_at(input int i);
      if (i < trig_q.size()) return trig_q[i];
      return 8'hxx;
   endfunction

   task automatic do_reset();
      @(negedge clk_in);
      rst_n_in    = 1'b0;
      move_req_in = 1'b0;
      rx_valid_in = 1'b0;
      repeat (3) @(negedge clk_in);
      trig_q.delete();
      trig_t.delete();
      mv_cnt  = 0;
      mv_last = 8'h00;
      rst_n_in = 1'b1;
      repeat (2) @(negedge clk_in);
   endtask

   task automatic pulse(input logic req, input logic [7:0] md, input logic rx, input logic [7:0] rd);
      @(negedge clk_in);
      move_req_in = req;
      move_in     = md;
      rx_valid_in = rx;
      rx_data_in  = rd;
      @(negedge clk_in);
      move_req_in = 1'b0;
      rx_valid_in = 1'b0;
   endtask

   task automatic wait_trigs(input int n, input int budget, input string name);
      for (int i = 0; i < budget && trig_q.size() < n; i++) @(negedge clk_in);
      check(name, trig_q.size(), n);
   endtask

   typedef struct {
      string      name;
      logic       do_req;
      logic [7:0] req_d;
      logic       do_rx;
      logic [7:0] rx_d;
      int         exp_trigs;
      logic [7:0] t0;
      logic [7:0] t1;
      int         exp_mv;
      logic [7:0] exp_mo;
      logic       exp_rdy;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int gap;

      vecs[0] = '{"send34",  1'b1, 8'h34, 1'b0, 8'h00, 1, 8'h34, 8'h00, 0, 8'h00, 1'b0};
      vecs[1] = '{"recv52",  1'b0, 8'h00, 1'b1, 8'h52, 1, 8'hFF, 8'h00, 1, 8'h52, 1'b1};
      vecs[2] = '{"collide", 1'b1, 8'h11, 1'b1, 8'h22, 2, 8'hFF, 8'h11, 1, 8'h22, 1'b0};
      vecs[3] = '{"ackidle", 1'b0, 8'h00, 1'b1, 8'hFF, 0, 8'h00, 8'h00, 0, 8'h00, 1'b1};
      vecs[4] = '{"send00",  1'b1, 8'h00, 1'b0, 8'h00, 1, 8'h00, 8'h00, 0, 8'h00, 1'b0};

      // reset state while reset is held
      repeat (2) @(negedge clk_in);
      check("rst_trig", tx_trigger_out, 0);
      check("rst_txdata", tx_data_out, 0);
      check("rst_mv", move_valid_out, 0);
      check("rst_rdy", req_ready_out, 0);
      check("rst_err", link_err_out, 0);
      rst_n_in = 1'b1;
      repeat (2) @(negedge clk_in);
      check("rdy_after_rst", req_ready_out, 1);

      for (int v = 0; v < 5; v++) begin
         do_reset();
         pulse(vecs[v].do_req, vecs[v].req_d, vecs[v].do_rx, vecs[v].rx_d);
         repeat (60) @(negedge clk_in);
         check({vecs[v].name, "_ntrig"}, trig_q.size(), vecs[v].exp_trigs);
         if (vecs[v].exp_trigs > 0) check({vecs[v].name, "_t0"}, trig_at(0), vecs[v].t0);
         if (vecs[v].exp_trigs > 1) check({vecs[v].name, "_t1"}, trig_at(1), vecs[v].t1);
         check({vecs[v].name, "_nmv"}, mv_cnt, vecs[v].exp_mv);
         if (vecs[v].exp_mv > 0) check({vecs[v].name, "_mo"}, mv_last, vecs[v].exp_mo);
         check({vecs[v].name, "_rdy"}, req_ready_out, vecs[v].exp_rdy);
      end

      // basic send confirmed by ACK, no retry afterwards
      do_reset();
      pulse(1'b1, 8'h34, 1'b0, 8'h00);
      wait_trigs(1, 40, "basic_trig");
      repeat (50) @(negedge clk_in);
      pulse(1'b0, 8'h00, 1'b1, 8'hFF);
      repeat (5) @(negedge clk_in);
      check("basic_rdy", req_ready_out, 1);
      repeat (300) @(negedge clk_in);
      check("basic_noretry", trig_q.size(), 1);
      check("basic_err", link_err_out, 0);

      // receive then duplicate: ACK resent, move delivered once
      do_reset();
      pulse(1'b0, 8'h00, 1'b1, 8'h52);
      repeat (30) @(negedge clk_in);
      pulse(1'b0, 8'h00, 1'b1, 8'h52);
      repeat (30) @(negedge clk_in);
      check("dup_ntrig", trig_q.size(), 2);
      check("dup_t1", trig_at(1), 8'hFF);
      check("dup_nmv", mv_cnt, 1);

      // retry exhaustion
      do_reset();
      pulse(1'b1, 8'h07, 1'b0, 8'h00);
      for (int i = 0; i < 800 && !link_err_out; i++) @(negedge clk_in);
      check("retry_err", link_err_out, 1);
      check("retry_ntrig", trig_q.size(), 4);
      for (int i = 0; i < 4; i++) check("retry_data", trig_at(i), 8'h07);
      for (int i = 1; i < 4 && i < trig_t.size(); i++) begin
         gap = trig_t[i] - trig_t[i-1];
         check("retry_gap", (gap >= TMO + 5) && (gap <= TMO + 15), 1);
      end
      pulse(1'b1, 8'h12, 1'b0, 8'h00);
      pulse(1'b0, 8'h00, 1'b1, 8'h33);
      repeat (200) @(negedge clk_in);
      check("err_ntrig", trig_q.size(), 4);
      check("err_nmv", mv_cnt, 0);
      check("err_rdy", req_ready_out, 0);
      check("err_sticky", link_err_out, 1);

      // implicit ACK from a peer move during WAIT_ACK
      do_reset();
      pulse(1'b1, 8'h40, 1'b0, 8'h00);
      wait_trigs(1, 40, "impl_trig");
      repeat (30) @(negedge clk_in);
      pulse(1'b0, 8'h00, 1'b1, 8'h63);
      repeat (40) @(negedge clk_in);
      check("impl_nmv", mv_cnt, 1);
      check("impl_mo", mv_last, 8'h63);
      check("impl_ack", trig_at(1), 8'hFF);
      check("impl_rdy", req_ready_out, 1);
      repeat (300) @(negedge clk_in);
      check("impl_noretry", trig_q.size(), 2);
      check("impl_err", link_err_out, 0);

      // async reset during WAIT_TX_MOVE, off a clock edge
      do_reset();
      pulse(1'b1, 8'h55, 1'b1, 8'h66);
      wait_trigs(2, 60, "arst_trig");
      repeat (2) @(posedge clk_in);
      #3;
      rst_n_in = 1'b0;
      #1;
      check("arst_trig0", tx_trigger_out, 0);
      check("arst_data0", tx_data_out, 0);
      check("arst_mv0", move_valid_out, 0);
      check("arst_mo0", move_out, 0);
      check("arst_rdy0", req_ready_out, 0);
      check("arst_err0", link_err_out, 0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      repeat (3) @(negedge clk_in);
      check("arst_rdy", req_ready_out, 1);
      repeat (50) @(negedge clk_in);
      check("arst_nospur", trig_q.size(), 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
